// File: rtl/mem8x8_pkg.sv
// mem8x8_pkg: shared FSM encoding, default widths and rw encoding for the mem8x8 controller
package mem8x8_pkg;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    VERIFY = 3'd2,
    READ   = 3'd3,
    RESP   = 3'd4
  } state_t;
endpackage

// File: rtl/mem8x8_ctrl_if.sv
// mem8x8_ctrl_if: host-side request/response bus of the mem8x8 controller
interface mem8x8_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_sel_decode.sv
// mem_sel_decode: ADDR_W to 2**ADDR_W one-hot row decoder with enable
module mem_sel_decode #(
  parameter int ADDR_W = 3
) (
  input  logic                 i_en,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic [2**ADDR_W-1:0] o_sel
);
  localparam int N = 2**ADDR_W;
  assign o_sel = i_en ? ({{(N-1){1'b0}}, 1'b1} << i_addr) : '0;
endmodule

// File: rtl/mem8x8_ctrl.sv
// mem8x8_ctrl: host request sequencer for the 8x8 byte-cell array.
// Optional write-verify readback is compiled in with MEM_CTRL_WRVERIFY_EN.
module mem8x8_ctrl
  import mem8x8_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WR_CYCLES = 1,
  parameter int RD_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem8x8_ctrl_if.slave         bus,
  output logic [DATA_W-1:0]    o_mem_inp,
  output logic                 o_mem_rw,
  output logic [2**ADDR_W-1:0] o_mem_sel,
  input  logic [DATA_W-1:0]    i_mem_outp
);
  localparam int MAX_CYC = WR_CYCLES > RD_CYCLES ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYC) + 1;
  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_ready;
  logic                  r_rsp_valid;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_rw;
  logic [2**ADDR_W-1:0]  r_sel;
  logic [2**ADDR_W-1:0]  w_onehot;
  logic                  w_acc;
  logic                  w_last_wr;
  logic                  w_last_rd;
  logic                  w_sel_en;
  assign w_acc     = bus.req_valid && r_ready;
  assign w_last_wr = r_cnt == CNT_W'(WR_CYCLES - 1);
  assign w_last_rd = r_cnt == CNT_W'(RD_CYCLES - 1);
  assign w_sel_en  = r_state inside {WRITE, VERIFY, READ};
  mem_sel_decode #(.ADDR_W(ADDR_W)) u_dec (
    .i_en   (w_sel_en),
    .i_addr (r_addr),
    .o_sel  (w_onehot)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   w_next = w_acc ? (bus.req_we ? WRITE : READ) : IDLE;
`ifdef MEM_CTRL_WRVERIFY_EN
      WRITE:  w_next = w_last_wr ? VERIFY : WRITE;
      VERIFY: w_next = w_last_rd ? RESP : VERIFY;
`else
      WRITE:  w_next = w_last_wr ? RESP : WRITE;
`endif
      READ:   w_next = w_last_rd ? RESP : READ;
      RESP:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Array controls are registered from the current state, so they trail it by
  // one cycle; the last select cycle therefore coincides with RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_rw        <= RW_READ;
      r_sel       <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= (w_next == r_state) ? r_cnt + 1'b1 : '0;
      r_ready     <= w_next == IDLE;
      r_rsp_valid <= r_state == RESP;
      r_rw        <= (r_state == WRITE) ? RW_WRITE : RW_READ;
      r_sel       <= w_onehot;
      if (w_acc) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if (r_state == RESP && !r_we) r_rdata <= i_mem_outp;
    end
  end
`ifdef MEM_CTRL_WRVERIFY_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else if (r_state == RESP) r_err <= r_we && (i_mem_outp != r_wdata);
  end
  assign bus.rsp_err = r_err;
`else
  assign bus.rsp_err = 1'b0;
`endif
  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign o_mem_inp     = r_wdata;
  assign o_mem_rw      = r_rw;
  assign o_mem_sel     = r_sel;
endmodule

// File: tb/tb_mem8x8_ctrl.sv
// tb_mem8x8_ctrl: directed bench for mem8x8_ctrl against a behavioural 8x8 array.
// Build with MEM_CTRL_WRVERIFY_EN to exercise the write-verify path.
module tb_mem8x8_ctrl;
`ifdef MEM_CTRL_WRVERIFY_EN
  localparam int WLAT = 3;
`else
  localparam int WLAT = 2;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem8x8_ctrl_if #(.ADDR_W(3), .DATA_W(8)) bus ();
  logic [7:0] mem_inp;
  logic       mem_rw;
  logic [7:0] mem_sel;
  logic [7:0] mem_outp;
  logic       corrupt = 1'b0;
  logic [7:0] mem [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
  int n_cmp = 0;
  int n_err = 0;
  int n_rsp = 0;
  int n_multi = 0;
  int n_rw0 = 0;
  mem8x8_ctrl #(.ADDR_W(3), .DATA_W(8), .WR_CYCLES(1), .RD_CYCLES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_mem_inp  (mem_inp),
    .o_mem_rw   (mem_rw),
    .o_mem_sel  (mem_sel),
    .i_mem_outp (mem_outp)
  );
  always_comb begin
    mem_outp = '0;
    for (int i = 0; i < 8; i++) if (mem_sel[i]) mem_outp = mem[i] ^ {7'b0, corrupt};
  end
  always @(posedge clk)
    for (int i = 0; i < 8; i++) if (!mem_rw && mem_sel[i]) mem[i] <= mem_inp;
  always @(negedge clk) begin
    if ($countones(mem_sel) > 1) n_multi++;
    if (!mem_rw) n_rw0++;
    if (bus.rsp_valid) n_rsp++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic we, input logic [2:0] a, input logic [7:0] d, output int lat);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_wdata = d;
    lat = 0;
    while (!bus.req_ready && lat < 20) begin
      tick();
      lat++;
    end
    tick();
    bus.req_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.rsp_valid && lat < 20);
  endtask
  initial begin
    int lat;
    int rw0;
    int nr;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    tick();
    tick();
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_sel", mem_sel, 8'h00);
    chk("rst_rw", mem_rw, 1);
    chk("rst_inp", mem_inp, 8'h00);
    chk("rst_rdata", bus.rsp_rdata, 8'h00);
    chk("rst_err", bus.rsp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 3'd3;
    bus.req_wdata = 8'hAA;
    chk("idle_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    chk("acc_ready_drop", bus.req_ready, 0);
    chk("acc_inp", mem_inp, 8'hAA);
    chk("acc_sel_pre", mem_sel, 8'h00);
    tick();
    chk("wr_sel", mem_sel, 8'b0000_1000);
    chk("wr_rw", mem_rw, 0);
    chk("wr_inp", mem_inp, 8'hAA);
    lat = 1;
    do begin
      tick();
      lat++;
    end while (!bus.rsp_valid && lat < 20);
    chk("wr_lat", lat, WLAT);
    chk("wr_rsp_sel", mem_sel, 8'h00);
    chk("wr_rsp_rw", mem_rw, 1);
    chk("wr_rsp_err", bus.rsp_err, 0);
    chk("wr_rsp_rdata_kept", bus.rsp_rdata, 8'h00);
    chk("mem3", mem[3], 8'hAA);
    tick();
    chk("rsp_pulse", bus.rsp_valid, 0);
    chk("ready_back", bus.req_ready, 1);
    rw0 = n_rw0;
    req(1'b0, 3'd3, 8'h00, lat);
    chk("rd3_lat", lat, 2);
    chk("rd3_data", bus.rsp_rdata, 8'hAA);
    chk("rd3_rw_high", n_rw0, rw0);
    req(1'b1, 3'd0, 8'hCC, lat);
    chk("wr0_lat", lat, WLAT);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 3'd7;
    bus.req_wdata = 8'hF0;
    lat = 0;
    while (!bus.req_ready && lat < 20) begin
      tick();
      lat++;
    end
    tick();
    bus.req_we = 1'b0;
    bus.req_addr = 3'd0;
    bus.req_wdata = 8'h00;
    lat = 0;
    do begin
      tick();
      lat++;
      if (!bus.rsp_valid) chk("busy_ready", bus.req_ready, 0);
    end while (!bus.rsp_valid && lat < 20);
    chk("wr7_lat", lat, WLAT);
    chk("wr7_rsp_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    chk("held_acc_ready", bus.req_ready, 0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.rsp_valid && lat < 20);
    chk("held_rd0_lat", lat, 2);
    chk("held_rd0_data", bus.rsp_rdata, 8'hCC);
    req(1'b0, 3'd7, 8'h00, lat);
    chk("rd7_data", bus.rsp_rdata, 8'hF0);
    req(1'b0, 3'd3, 8'h00, lat);
    chk("rd3_again", bus.rsp_rdata, 8'hAA);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 3'd5;
    bus.req_wdata = 8'h77;
    lat = 0;
    while (!bus.req_ready && lat < 20) begin
      tick();
      lat++;
    end
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("wr5_sel", mem_sel, 8'b0010_0000);
    chk("wr5_rw", mem_rw, 0);
    nr = n_rsp;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_sel", mem_sel, 8'h00);
    chk("midrst_rw", mem_rw, 1);
    chk("midrst_ready", bus.req_ready, 1);
    chk("midrst_rsp", bus.rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("midrst_no_rsp", n_rsp, nr);
    chk("mem5_kept", mem[5], 8'h15);
    req(1'b0, 3'd5, 8'h00, lat);
    chk("rd5_data", bus.rsp_rdata, 8'h15);
`ifdef MEM_CTRL_WRVERIFY_EN
    corrupt = 1'b1;
    req(1'b1, 3'd2, 8'h55, lat);
    chk("vfy_bad_lat", lat, 3);
    chk("vfy_bad_err", bus.rsp_err, 1);
    corrupt = 1'b0;
    req(1'b1, 3'd2, 8'h55, lat);
    chk("vfy_ok_lat", lat, 3);
    chk("vfy_ok_err", bus.rsp_err, 0);
`else
    req(1'b1, 3'd2, 8'h55, lat);
    chk("wr2_lat", lat, 2);
    chk("wr2_err", bus.rsp_err, 0);
`endif
    chk("mem2", mem[2], 8'h55);
    chk("one_hot", n_multi, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
